// File: rtl/cla_alu_pipe.sv
// cla_alu_pipe: pipelined carry-lookahead add/sub unit with valid/ready handshake.
// Each stage resolves one slice of groups; upper operands skew forward, lower results trail.
module cla_alu_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] band,
    output logic [WIDTH-1:0] bxor,
    output logic             cout,
    output logic             of,
    output logic             zero
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / GROUP;

    logic             advance;
    logic [WIDTH-1:0] bp_in;
    logic             c0_in;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign bp_in    = b ^ {WIDTH{sub}};
    assign c0_in    = sub | cin;

    // Carries c[0..SW] for one slice: full lookahead inside a group, group carries ripple.
    function automatic logic [SW:0] slice_carries(input logic [SW-1:0] p,
                                                  input logic [SW-1:0] g,
                                                  input logic          c_in);
        logic [SW:0] c;
        logic        term;
        logic        prod;
        int          base;
        c    = '0;
        c[0] = c_in;
        for (int grp = 0; grp < int'(NG); grp++) begin
            base = grp * int'(GROUP);
            for (int i = 0; i < int'(GROUP); i++) begin
                term = g[base + i];
                prod = p[base + i];
                for (int j = i - 1; j >= 0; j--) begin
                    term = term | (prod & g[base + j]);
                    prod = prod & p[base + j];
                end
                c[base + i + 1] = term | (prod & c[base]);
            end
        end
        return c;
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int unsigned LO = k * SW;
        localparam int unsigned HI = (k + 1) * SW;

        logic [SW-1:0] s_a;
        logic [SW-1:0] s_bp;
        logic [SW-1:0] s_p;
        logic [SW-1:0] s_g;
        logic [SW-1:0] s_sum;
        logic [SW:0]   s_cy;
        logic          s_c;
        logic          s_valid;

        if (k == 0) begin : src
            assign s_a     = a[SW-1:0];
            assign s_bp    = bp_in[SW-1:0];
            assign s_c     = c0_in;
            assign s_valid = in_valid;
        end else begin : src
            assign s_a     = stg[k-1].mid.r_a[SW-1:0];
            assign s_bp    = stg[k-1].mid.r_bp[SW-1:0];
            assign s_c     = stg[k-1].mid.r_c;
            assign s_valid = stg[k-1].mid.r_valid;
        end

        assign s_p   = s_a ^ s_bp;
        assign s_g   = s_a & s_bp;
        assign s_cy  = slice_carries(s_p, s_g, s_c);
        assign s_sum = s_p ^ s_cy[SW-1:0];

        if (k < STAGES - 1) begin : mid
            logic [WIDTH-HI-1:0] r_a;
            logic [WIDTH-HI-1:0] r_bp;
            logic [HI-1:0]       r_sum;
            logic [HI-1:0]       r_band;
            logic [HI-1:0]       r_bxor;
            logic                r_c;
            logic                r_valid;
            logic [WIDTH-HI-1:0] u_a;
            logic [WIDTH-HI-1:0] u_bp;
            logic [HI-1:0]       n_sum;
            logic [HI-1:0]       n_band;
            logic [HI-1:0]       n_bxor;

            if (k == 0) begin : fwd
                assign u_a    = a[WIDTH-1:HI];
                assign u_bp   = bp_in[WIDTH-1:HI];
                assign n_sum  = s_sum;
                assign n_band = s_g;
                assign n_bxor = s_p;
            end else begin : fwd
                assign u_a    = stg[k-1].mid.r_a[WIDTH-LO-1:SW];
                assign u_bp   = stg[k-1].mid.r_bp[WIDTH-LO-1:SW];
                assign n_sum  = {s_sum, stg[k-1].mid.r_sum};
                assign n_band = {s_g, stg[k-1].mid.r_band};
                assign n_bxor = {s_p, stg[k-1].mid.r_bxor};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_a     <= '0;
                    r_bp    <= '0;
                    r_c     <= 1'b0;
                    r_sum   <= '0;
                    r_band  <= '0;
                    r_bxor  <= '0;
                end else if (advance) begin
                    r_valid <= s_valid;
                    r_a     <= u_a;
                    r_bp    <= u_bp;
                    r_c     <= s_cy[SW];
                    r_sum   <= n_sum;
                    r_band  <= n_band;
                    r_bxor  <= n_bxor;
                end
            end
        end else begin : fin
            logic [WIDTH-1:0] n_sum;
            logic [WIDTH-1:0] n_band;
            logic [WIDTH-1:0] n_bxor;

            if (k == 0) begin : cat
                assign n_sum  = s_sum;
                assign n_band = s_g;
                assign n_bxor = s_p;
            end else begin : cat
                assign n_sum  = {s_sum, stg[k-1].mid.r_sum};
                assign n_band = {s_g, stg[k-1].mid.r_band};
                assign n_bxor = {s_p, stg[k-1].mid.r_bxor};
            end

            // Final stage owns the MSB group, so both flag carries are visible here.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    band      <= '0;
                    bxor      <= '0;
                    cout      <= 1'b0;
                    of        <= 1'b0;
                    zero      <= 1'b0;
                end else if (advance) begin
                    out_valid <= s_valid;
                    sum       <= n_sum;
                    band      <= n_band;
                    bxor      <= n_bxor;
                    cout      <= s_cy[SW];
                    of        <= s_cy[SW] ^ s_cy[SW-1];
                    zero      <= (n_sum == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_alu_pipe.sv
// Self-checking bench for cla_alu_pipe: runs the same scenarios on a 32/4/2 and a 64/8/4 instance.
module tb_cla_alu_pipe;
    typedef struct packed {
        logic [63:0] sum;
        logic [63:0] band;
        logic [63:0] bxor;
        logic        cout;
        logic        of;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        sel;
    int          w;
    int          lat;
    int          checks = 0;
    int          passed = 0;
    res_t        q[$];

    always #5 clk = ~clk;

    logic        ir32, ov32, co32, of32, z32;
    logic [31:0] s32, an32, x32;
    logic        ir64, ov64, co64, of64, z64;
    logic [63:0] s64, an64, x64;

    cla_alu_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir32),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready & ~sel),
        .sum(s32), .band(an32), .bxor(x32), .cout(co32), .of(of32), .zero(z32)
    );

    cla_alu_pipe #(.WIDTH(64), .GROUP(8), .STAGES(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir64),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov64), .out_ready(out_ready & sel),
        .sum(s64), .band(an64), .bxor(x64), .cout(co64), .of(of64), .zero(z64)
    );

    logic obs_ir;
    logic obs_ov;
    res_t obs;

    always_comb begin
        obs_ir    = sel ? ir64 : ir32;
        obs_ov    = sel ? ov64 : ov32;
        obs.sum   = sel ? s64  : {32'h0, s32};
        obs.band  = sel ? an64 : {32'h0, an32};
        obs.bxor  = sel ? x64  : {32'h0, x32};
        obs.cout  = sel ? co64 : co32;
        obs.of    = sel ? of64 : of32;
        obs.zero  = sel ? z64  : z32;
    end

    // Reference: wide integer add, flags from the sign bits rather than a carry chain.
    function automatic res_t model(input logic [63:0] xa, input logic [63:0] xb,
                                   input logic xc, input logic xs, input int ww);
        res_t        r;
        logic [64:0] full;
        logic [63:0] m;
        logic [63:0] bp;
        logic        cmsb;
        m      = (ww == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
        bp     = (xs ? ~xb : xb) & m;
        xa     = xa & m;
        full   = {1'b0, xa} + {1'b0, bp} + 65'(xs | xc);
        r.sum  = full[63:0] & m;
        r.cout = (ww == 64) ? full[64] : full[32];
        cmsb   = r.sum[ww-1] ^ xa[ww-1] ^ bp[ww-1];
        r.of   = cmsb ^ r.cout;
        r.zero = (r.sum == 64'h0);
        r.band = xa & bp;
        r.bxor = xa ^ bp;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs_ov !== 1'b0) $display("FAIL reset_out_valid got=%b expected=0", obs_ov);
        else passed++;
        checks++;
        if (obs !== '0) $display("FAIL reset_outputs got=%h expected=0", obs);
        else passed++;
        checks++;
        if (obs_ir !== 1'b1) $display("FAIL reset_in_ready got=%b expected=1", obs_ir);
        else passed++;
    endtask

    task automatic test_directed();
        logic [63:0] m, msb, va, vb, vbp, es;
        logic        vc, vs;
        logic [2:0]  ef;
        int          n;
        m   = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
        msb = 64'd1 << (w - 1);
        for (int v = 0; v < 7; v++) begin
            case (v)
                0: begin va = 64'd5;  vb = 64'd3; vc = 1'b0; vs = 1'b0; es = 64'd8;     ef = 3'b000; end
                1: begin va = m;      vb = 64'd1; vc = 1'b0; vs = 1'b0; es = 64'd0;     ef = 3'b101; end
                2: begin va = m >> 1; vb = 64'd1; vc = 1'b0; vs = 1'b0; es = msb;       ef = 3'b010; end
                3: begin va = 64'd5;  vb = 64'd7; vc = 1'b0; vs = 1'b1; es = m - 64'd1; ef = 3'b000; end
                4: begin va = msb;    vb = 64'd1; vc = 1'b0; vs = 1'b1; es = m >> 1;    ef = 3'b110; end
                5: begin va = 64'd1;  vb = 64'd1; vc = 1'b1; vs = 1'b0; es = 64'd3;     ef = 3'b000; end
                default: begin va = 64'd7; vb = 64'd7; vc = 1'b1; vs = 1'b1; es = 64'd0; ef = 3'b101; end
            endcase
            vbp = (vs ? ~vb : vb) & m;
            a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++;
            if (obs_ir !== 1'b1) $display("FAIL directed%0d_in_ready got=%b expected=1", v, obs_ir);
            else passed++;
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0; a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
            cin = ~vc; sub = ~vs;
            n = 1;
            while (!obs_ov && n < 12) begin
                @(posedge clk); @(negedge clk);
                n++;
            end
            checks++;
            if (n !== lat) $display("FAIL directed%0d_latency got=%0d expected=%0d", v, n, lat);
            else passed++;
            checks++;
            if (obs.sum !== es) $display("FAIL directed%0d_sum got=%h expected=%h", v, obs.sum, es);
            else passed++;
            checks++;
            if ({obs.cout, obs.of, obs.zero} !== ef)
                $display("FAIL directed%0d_flags cout/of/zero got=%b expected=%b", v, {obs.cout, obs.of, obs.zero}, ef);
            else passed++;
            checks++;
            if ({obs.band, obs.bxor} !== {va & vbp, va ^ vbp})
                $display("FAIL directed%0d_logic band=%h bxor=%h expected band=%h bxor=%h",
                         v, obs.band, obs.bxor, va & vbp, va ^ vbp);
            else passed++;
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   sent, got, cyc, first, last;
        res_t e;
        q.delete();
        sent = 0; got = 0; cyc = 0; first = -1; last = -1;
        out_ready = 1'b1;
        while ((sent < 8 || got < 8) && cyc < 60) begin
            if (sent < 8) begin
                in_valid = 1'b1;
                a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (obs_ov && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL b2b_unexpected got=%h expected no output", obs);
                end else begin
                    e = q.pop_front();
                    if (obs !== e) $display("FAIL b2b_result%0d got=%h expected=%h", got, obs, e);
                    else passed++;
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (in_valid && obs_ir) begin
                q.push_back(model(a, b, cin, sub, w));
                sent++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 8) $display("FAIL b2b_count got=%0d expected=8", got);
        else passed++;
        checks++;
        if (last - first !== 7) $display("FAIL b2b_throughput span got=%0d expected=7", last - first);
        else passed++;
        checks++;
        if (q.size() !== 0) $display("FAIL b2b_leftover got=%0d expected=0", q.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        int   sent, got, cyc, moved, extra;
        logic have;
        res_t snap, e;
        q.delete();
        sent = 0; got = 0; moved = 0; have = 1'b0; snap = '0; extra = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            if (obs_ir) begin
                q.push_back(model(a, b, cin, sub, w));
                sent++;
            end
            if (obs_ov) begin
                if (!have) begin snap = obs; have = 1'b1; end
                else if (obs !== snap) moved++;
            end
            @(posedge clk); @(negedge clk);
        end
        a = {$urandom(), $urandom()};
        #1;
        checks++;
        if (sent !== lat) $display("FAIL bp_fill accepted=%0d expected=%0d", sent, lat);
        else passed++;
        checks++;
        if (obs_ir !== 1'b0) $display("FAIL bp_in_ready got=%b expected=0", obs_ir);
        else passed++;
        checks++;
        if (obs_ov !== 1'b1) $display("FAIL bp_out_valid got=%b expected=1", obs_ov);
        else passed++;
        checks++;
        if (moved !== 0 || obs !== snap) $display("FAIL bp_stable changes=%0d got=%h expected=%h", moved, obs, snap);
        else passed++;
        // Release with new bundles still offered: full pipe drains and refills on the same edges.
        out_ready = 1'b1;
        cyc = 0;
        while ((extra < 3 || got < sent) && cyc < 40) begin
            if (extra < 3) begin
                in_valid = 1'b1;
                a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 0) begin
                checks++;
                if (obs_ir !== 1'b1) $display("FAIL bp_release_in_ready got=%b expected=1", obs_ir);
                else passed++;
            end
            if (obs_ov) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL bp_duplicate got=%h expected no output", obs);
                end else begin
                    e = q.pop_front();
                    if (obs !== e) $display("FAIL bp_result%0d got=%h expected=%h", got, obs, e);
                    else passed++;
                end
                got++;
            end
            if (in_valid && obs_ir) begin
                q.push_back(model(a, b, cin, sub, w));
                sent++;
                extra++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== lat + 3) $display("FAIL bp_count got=%0d expected=%0d", got, lat + 3);
        else passed++;
        checks++;
        if (q.size() !== 0) $display("FAIL bp_leftover got=%0d expected=0", q.size());
        else passed++;
    endtask

    task automatic test_reset_flight();
        int ghosts;
        q.delete();
        ghosts = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            a = {$urandom(), $urandom()} | 64'd1; b = {$urandom(), $urandom()};
            cin = 1'b0; sub = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        checks++;
        if (obs_ov !== 1'b0) $display("FAIL flight_out_valid got=%b expected=0", obs_ov);
        else passed++;
        checks++;
        if (obs !== '0) $display("FAIL flight_outputs got=%h expected=0", obs);
        else passed++;
        checks++;
        if (obs_ir !== 1'b1) $display("FAIL flight_in_ready got=%b expected=1", obs_ir);
        else passed++;
        rst = 1'b0;
        for (int c = 0; c < lat + 3; c++) begin
            @(posedge clk); @(negedge clk);
            if (obs_ov) ghosts++;
        end
        checks++;
        if (ghosts !== 0) $display("FAIL flight_discard outputs=%0d expected=0", ghosts);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; sel = 1'b0;
        w = 32; lat = 2;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            w   = (s == 1) ? 64 : 32;
            lat = (s == 1) ? 4 : 2;
            @(negedge clk);
            test_reset();
            test_directed();
            test_back_to_back();
            test_backpressure();
            test_reset_flight();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

endmodule
